// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared types and constants for the UART host command sequencer.
package uart_cmd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT_DATA,
    ST_WRITE,
    ST_READ_CAP,
    ST_TX_PUSH,
    ST_ACK
  } uart_cmd_state_t;

  localparam int         CMD_WR_BIT    = 7;
  localparam logic [7:0] CMD_RSVD_MASK = 8'h78;
  localparam logic [7:0] CMD_ADDR_MASK = 8'h07;
  localparam logic [7:0] UART_ACK_BASE = 8'h80;

  localparam logic [2:0] UART_DR_OFFSET  = 3'd0;
  localparam logic [2:0] UART_SR_OFFSET  = 3'd1;
  localparam logic [2:0] UART_CR_OFFSET  = 3'd2;
  localparam logic [2:0] UART_BRD_OFFSET = 3'd3;

  function automatic logic cmd_is_rsvd(input logic [7:0] c);
    return (c & CMD_RSVD_MASK) != 8'h00;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// FIFO and register-file handshake bundle seen by the command sequencer.
interface uart_cmd_ctrl_if;
  logic [7:0] i_rx_data;
  logic       i_rx_empty;
  logic       o_rx_rd;
  logic [7:0] o_tx_data;
  logic       o_tx_wr;
  logic       i_tx_full;
  logic [2:0] o_rwaddr;
  logic [7:0] o_write_data;
  logic       o_wr_req;
  logic       o_rd_req;
  logic [7:0] i_read_data;

  modport master (
    input  i_rx_data, i_rx_empty, i_tx_full, i_read_data,
    output o_rx_rd, o_tx_data, o_tx_wr, o_rwaddr, o_write_data, o_wr_req, o_rd_req
  );

  modport slave (
    output i_rx_data, i_rx_empty, i_tx_full, i_read_data,
    input  o_rx_rd, o_tx_data, o_tx_wr, o_rwaddr, o_write_data, o_wr_req, o_rd_req
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Host byte-protocol sequencer: RX FIFO commands -> register strobes, read data -> TX FIFO.
// UART_CMD_ECHO_EN adds a write-acknowledge byte (8'h80 | addr) pushed to the TX FIFO.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  uart_cmd_ctrl_if.master  bus,
  output logic             o_err,
  output logic             o_busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  uart_cmd_state_t state;
  logic [7:0]      cmd;
  logic [7:0]      wdata;
  logic [7:0]      rdbuf;
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= ST_IDLE;
      cmd              <= '0;
      wdata            <= '0;
      rdbuf            <= '0;
      to_cnt           <= '0;
      bus.o_rx_rd      <= 1'b0;
      bus.o_tx_data    <= '0;
      bus.o_tx_wr      <= 1'b0;
      bus.o_rwaddr     <= '0;
      bus.o_write_data <= '0;
      bus.o_wr_req     <= 1'b0;
      bus.o_rd_req     <= 1'b0;
      o_err            <= 1'b0;
      o_busy           <= 1'b0;
    end else begin
      // strobes default low; address/data hold between requests
      bus.o_rx_rd  <= 1'b0;
      bus.o_tx_wr  <= 1'b0;
      bus.o_wr_req <= 1'b0;
      bus.o_rd_req <= 1'b0;
      o_err        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!bus.i_rx_empty) begin
            bus.o_rx_rd <= 1'b1;
            cmd         <= bus.i_rx_data;
            state       <= ST_DECODE;
            o_busy      <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (cmd_is_rsvd(cmd)) begin
            o_err  <= 1'b1;
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else if (cmd[CMD_WR_BIT]) begin
            to_cnt <= '0;
            state  <= ST_WAIT_DATA;
          end else begin
            bus.o_rwaddr <= cmd[2:0];
            bus.o_rd_req <= 1'b1;
            state        <= ST_READ_CAP;
          end
        end
        ST_WAIT_DATA: begin
          if (!bus.i_rx_empty) begin
            bus.o_rx_rd <= 1'b1;
            wdata       <= bus.i_rx_data;
            state       <= ST_WRITE;
          end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            o_err  <= 1'b1;
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_WRITE: begin
          bus.o_rwaddr     <= cmd[2:0];
          bus.o_write_data <= wdata;
          bus.o_wr_req     <= 1'b1;
`ifdef UART_CMD_ECHO_EN
          state            <= ST_ACK;
`else
          state            <= ST_IDLE;
          o_busy           <= 1'b0;
`endif
        end
        ST_READ_CAP: begin
          rdbuf <= bus.i_read_data;
          state <= ST_TX_PUSH;
        end
        ST_TX_PUSH: begin
          // waits indefinitely on a full TX FIFO; the host drains it
          if (!bus.i_tx_full) begin
            bus.o_tx_wr   <= 1'b1;
            bus.o_tx_data <= rdbuf;
            state         <= ST_IDLE;
            o_busy        <= 1'b0;
          end
        end
`ifdef UART_CMD_ECHO_EN
        ST_ACK: begin
          if (!bus.i_tx_full) begin
            bus.o_tx_wr   <= 1'b1;
            bus.o_tx_data <= UART_ACK_BASE | {5'b0, cmd[2:0]};
            state         <= ST_IDLE;
            o_busy        <= 1'b0;
          end
        end
`endif
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
